// File: rtl/instr_encoder.sv
// RV32I field encoder feeding a 4-entry write FIFO toward instruction memory; accept->mem_valid is 1 cycle.
// in_ready drops while the FIFO is full. Define ENC_RANGE_CHECK_EN to drop out-of-range immediates and raise sticky err.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        load_base,
  input  logic [31:0] base_addr,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [15:0] count,
  output logic        err
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_U    = 7'b0110111;

  logic [31:0] enc_word;
  logic        enc_drop;
  logic        accept;
  logic        push;
  logic        pop;

  logic [31:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  occ;
  logic [31:0] addr_q;
  logic [15:0] count_q;

`ifdef ENC_RANGE_CHECK_EN
  logic i_ok, b_ok, j_ok, u_ok;
  logic err_q;

  // Upper bits must all equal the sign bit of the field being encoded.
  assign i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign j_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
  assign u_ok = ~(|in_imm[11:0]);
`endif

  always_comb begin
    enc_word = '0;
    enc_drop = 1'b0;
    case (in_class)
      3'd0: enc_word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
      3'd2: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      3'd3: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
      3'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], OP_B};
      3'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_J};
      3'd6: enc_word = {in_imm[31:12], in_rd, OP_U};
      default: enc_drop = 1'b1;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    case (in_class)
      3'd1, 3'd2, 3'd3: if (!i_ok) enc_drop = 1'b1;
      3'd4:             if (!b_ok) enc_drop = 1'b1;
      3'd5:             if (!j_ok) enc_drop = 1'b1;
      3'd6:             if (!u_ok) enc_drop = 1'b1;
      default: ;
    endcase
`endif
  end

  assign in_ready  = (occ != 3'd4);
  assign mem_valid = (occ != 3'd0);
  assign mem_data  = fifo_mem[rd_ptr];
  assign mem_addr  = addr_q;
  assign count     = count_q;

  assign accept = in_valid & in_ready;
  assign push   = accept & ~enc_drop;
  assign pop    = mem_valid & mem_ready;

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: ;
      endcase
      // A write coinciding with load_base still used the old address.
      if (load_base)  addr_q <= base_addr;
      else if (pop)   addr_q <= addr_q + 32'd4;
      if (pop && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

`ifdef ENC_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                      err_q <= 1'b0;
    else if (accept && enc_drop)  err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed cases plus randomized traffic against a field-arithmetic reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        load_base;
  logic [31:0] base_addr;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr, mem_data;
  logic [15:0] count;
  logic        err;

  instr_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .load_base(load_base), .base_addr(base_addr),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_addr = '0;
  int          m_count = 0;
  logic        m_err = 1'b0;
  logic        seen_rst = 1'b0;
  logic        use_gold = 1'b0;
  logic [31:0] gold_dat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding: each immediate bit range is pulled out with shifts/masks and dropped at its place.
  function automatic logic [31:0] ref_word(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w, vrd, vf3, vrs1, vrs2;
    vrd = 32'(rd) << 7;  vf3 = 32'(f3) << 12;
    vrs1 = 32'(rs1) << 15; vrs2 = 32'(rs2) << 20;
    case (cls)
      3'd0: w = 32'h33 | vrd | vf3 | vrs1 | vrs2 | (32'(f7) << 30);
      3'd1: w = 32'h13 | vrd | vf3 | vrs1 | ((imm & 32'hFFF) << 20);
      3'd2: w = 32'h03 | vrd | vf3 | vrs1 | ((imm & 32'hFFF) << 20);
      3'd3: w = 32'h23 | vf3 | vrs1 | vrs2 | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      3'd4: w = 32'h63 | vf3 | vrs1 | vrs2 | (((imm >> 12) & 32'h1) << 31) |
                (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      3'd5: w = 32'h6F | vrd | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
      3'd6: w = 32'h37 | vrd | (imm & 32'hFFFFF000);
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic ref_bad(input logic [2:0] cls, input logic [31:0] imm);
    int s;
    logic b;
    s = $signed(imm);
    b = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    case (cls)
      3'd1, 3'd2, 3'd3: b = (s < -2048) || (s > 2047);
      3'd4: b = (s < -4096) || (s > 4095) || imm[0];
      3'd5: b = (s < -1048576) || (s > 1048575) || imm[0];
      3'd6: b = ((imm & 32'hFFF) != 0);
      default: b = 1'b0;
    endcase
`endif
    return b;
  endfunction

  // Monitor: compare the DUT's view against the model, then advance the model by this cycle's handshakes.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_addr   = '0;
      m_count  = 0;
      m_err    = 1'b0;
      seen_rst = 1'b1;
    end else if (seen_rst) begin
      logic rdy_exp;
      rdy_exp = (exp_q.size() < 4);
      chk("in_ready", 32'(in_ready), 32'(rdy_exp));
      chk("mem_valid", 32'(mem_valid), 32'(exp_q.size() > 0));
      chk("mem_addr", mem_addr, m_addr);
      chk("count", 32'(count), 32'(m_count));
      chk("err", 32'(err), 32'(m_err));
      if (exp_q.size() > 0) chk("mem_data", mem_data, exp_q[0]);
      if (mem_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        m_addr = m_addr + 32'd4;
        if (m_count < 65535) m_count++;
      end
      if (load_base) m_addr = base_addr;
      if (in_valid && rdy_exp) begin
        if (in_class == 3'd7) begin
`ifdef ENC_RANGE_CHECK_EN
          m_err = 1'b1;
`endif
        end else if (ref_bad(in_class, in_imm)) begin
          m_err = 1'b1;
        end else begin
          exp_q.push_back(use_gold ? gold_dat :
                          ref_word(in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm);
    in_class = c; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Hold in_valid until accepted, bounded.
  task automatic send(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic g_use, input logic [31:0] g_dat);
    logic acc, ok;
    set_fields(c, f3, f7, rd, rs1, rs2, imm);
    use_gold = g_use; gold_dat = g_dat;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
    use_gold = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready never rose within 50 cycles, required 1");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; load_base = 1'b0; base_addr = '0; mem_ready = 1'b0;
    set_fields(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // add x3,x1,x2
    mem_ready = 1'b1;
    send(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    chk("r_valid", 32'(mem_valid), 32'd1);
    chk("r_data", mem_data, 32'h002081B3);
    chk("r_addr", mem_addr, 32'h0);
    tick();
    chk("r_count", 32'(count), 32'd1);

    // addi x1,x0,5 ; sw x2,8(x1) after a reset so addresses start at 0
    rst = 1'b1; tick(); rst = 1'b0;
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
    send(3'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020A423);
    chk("sw_addr", mem_addr, 32'h4);
    chk("sw_data", mem_data, 32'h0020A423);
    tick(); tick();

    // beq x0,x0,-4 at a loaded base
    base_addr = 32'h100; load_base = 1'b1; tick(); load_base = 1'b0;
    send(3'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3);
    chk("beq_addr", mem_addr, 32'h100);
    chk("beq_data", mem_data, 32'hFE000EE3);
    tick(); tick();

    // Fill to full with memory stalled: five offered, four taken.
    rst = 1'b1; tick(); rst = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_fields(3'd1, 3'(i), 1'b0, 5'(i + 1), 5'(i), 5'd0, 32'(i * 3));
      in_valid = 1'b1;
      tick();
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("full_hold_data", mem_data, ref_word(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0));
    in_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("full_count", 32'(count), 32'd4);
    chk("full_addr", mem_addr, 32'd16);

    // Reset with three entries buffered.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_fields(3'd6, 3'd0, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i) << 12);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1; mem_ready = 1'b1; tick(); rst = 1'b0;
    chk("rstmid_valid", 32'(mem_valid), 32'd0);
    chk("rstmid_count", 32'(count), 32'd0);
    chk("rstmid_addr", mem_addr, 32'd0);

    // Class 7 is swallowed.
    send(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'd0);
    chk("cls7_valid", 32'(mem_valid), 32'd0);
`ifdef ENC_RANGE_CHECK_EN
    chk("cls7_err", 32'(err), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b0, 32'd0);
    chk("range_valid", 32'(mem_valid), 32'd0);
    chk("range_err", 32'(err), 32'd1);
    send(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h7FF, 1'b1, 32'h7FF00093);
    chk("range_next_valid", 32'(mem_valid), 32'd1);
    tick();
    chk("range_err_held", 32'(err), 32'd1);
`else
    chk("cls7_err", 32'(err), 32'd0);
`endif

    // Randomized traffic with holds, stalls, base reloads (incl. wraparound) and occasional reset.
    begin
      logic acc;
      acc = 1'b1;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (acc || !in_valid) begin
          logic [31:0] imm;
          logic [2:0]  c;
          c = 3'($urandom_range(0, 7));
          case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($signed($urandom_range(0, 4095)) - 2048);
            2: imm = 32'($signed($urandom_range(0, 8191)) - 4096) & 32'hFFFFFFFE;
            default: imm = $urandom & 32'hFFFFF000;
          endcase
          set_fields(c, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
          in_valid = ($urandom_range(0, 9) < 7);
        end
        mem_ready = ($urandom_range(0, 9) < 6);
        load_base = ($urandom_range(0, 39) == 0);
        base_addr = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFF4 : ($urandom & 32'hFFFFFFFC);
        rst = ($urandom_range(0, 299) == 0);
        @(negedge clk);
        acc = in_valid & in_ready;
        tick();
      end
    end
    rst = 1'b0; load_base = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("drain_valid", 32'(mem_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
